// File: rtl/sr_trace_buffer.sv
// sr_trace_buffer
//   Execution-trace monitor for sr_cpu. Each enabled cycle captures {pc, instr, a0}
//   into a circular buffer that is drained through a show-ahead pop port. Two
//   watchdogs end capture:
//     - timeout: TIMEOUT captures have been taken;
//     - halt: the PC has repeated for STALL_LIMIT consecutive captures.
//   Both conditions are terminal until clr or reset. Pops still work afterwards.
//
// Ports
//   clk, rst_n            CPU clock; asynchronous active-low reset
//   clr                   synchronous clear, overrides every other input
//   en                    sample strobe (one capture per clk)
//   pc, instr, a0         traced CPU state
//   rd_pop                consume the entry currently shown on rd_*
//   rd_valid              buffer not empty
//   rd_pc/rd_instr/rd_a0  oldest entry (driven to 0 while empty)
//   count                 entries held
//   overflow              sticky: a sample was dropped or overwrote an entry
//   cycle                 captures since reset/clr, saturating
//   halt, timeout         sticky watchdog flags
module sr_trace_buffer #(
    parameter int DEPTH       = 16,
    parameter int MODE_STOP   = 0,
    parameter int TIMEOUT     = 120,
    parameter int STALL_LIMIT = 8,
    parameter int CNT_W       = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       en,
    input  logic [31:0]                pc,
    input  logic [31:0]                instr,
    input  logic [31:0]                a0,
    input  logic                       rd_pop,
    output logic                       rd_valid,
    output logic [31:0]                rd_pc,
    output logic [31:0]                rd_instr,
    output logic [31:0]                rd_a0,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic [CNT_W-1:0]           cycle,
    output logic                       halt,
    output logic                       timeout
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);
    localparam int SW = $clog2(STALL_LIMIT+2);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [SW-1:0] STALL_C = SW'(STALL_LIMIT);
    // A TIMEOUT that cycle can never reach behaves as disabled.
    localparam bit TO_EN = (TIMEOUT != 0) && ((TIMEOUT >> CNT_W) == 0);
    localparam logic [CNT_W-1:0] TO_C = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {RUN, HALT, TOUT} state_t;

    state_t          r_state, w_state_nxt;
    logic [95:0]     r_mem [DEPTH];
    logic [PW-1:0]   r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic [CNT_W-1:0] r_cycle;
    logic [SW-1:0]   r_stall;
    logic [31:0]     r_prev_pc;
    logic            r_have_prev;
    logic            r_overflow;

    logic            w_cap, w_pop, w_full, w_push, w_ovw, w_lost;
    logic [CNT_W-1:0] w_cycle_nxt;
    logic [SW-1:0]   w_stall_nxt;
    logic            w_halt_hit, w_tout_hit;
    logic [95:0]     w_rd;

    assign w_cap  = !clr && en && (r_state == RUN);
    assign w_pop  = !clr && rd_pop && (r_count != '0);
    assign w_full = (r_count == DEPTH_C);
    // Normal push: room available, or a simultaneous pop frees the slot.
    assign w_push = w_cap && (!w_full || w_pop);
    assign w_lost = w_cap && w_full && !w_pop;
    assign w_ovw  = w_lost && (MODE_STOP == 0);

    assign w_cycle_nxt = (r_cycle == '1) ? r_cycle : r_cycle + CNT_W'(1);
    // The first capture after reset/clr has no previous PC to match.
    assign w_stall_nxt = (r_have_prev && (pc == r_prev_pc))
                       ? ((r_stall == '1) ? r_stall : r_stall + SW'(1)) : '0;
    assign w_halt_hit  = (STALL_LIMIT != 0) && (w_stall_nxt == STALL_C);
    assign w_tout_hit  = TO_EN && (w_cycle_nxt == TO_C);

    always_comb begin
        w_state_nxt = r_state;
        if (w_cap) begin
            // Timeout takes precedence when both trigger on one capture.
            if (w_tout_hit)
                w_state_nxt = TOUT;
            else if (w_halt_hit)
                w_state_nxt = HALT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= RUN;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_cycle     <= '0;
            r_stall     <= '0;
            r_have_prev <= 1'b0;
            r_overflow  <= 1'b0;
        end else if (clr) begin
            r_state     <= RUN;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_cycle     <= '0;
            r_stall     <= '0;
            r_have_prev <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_cap) begin
                r_cycle     <= w_cycle_nxt;
                r_stall     <= w_stall_nxt;
                r_have_prev <= 1'b1;
            end
            if (w_push || w_ovw)
                r_wr_ptr <= r_wr_ptr + PW'(1);
            // Overwrite discards the oldest entry, so the read side advances too.
            if (w_pop || w_ovw)
                r_rd_ptr <= r_rd_ptr + PW'(1);
            if (w_push && !w_pop)
                r_count <= r_count + CW'(1);
            else if (!w_push && w_pop)
                r_count <= r_count - CW'(1);
            if (w_lost)
                r_overflow <= 1'b1;
        end
    end

    // Trace storage and last-PC holder carry no reset; validity lives in the control state.
    always_ff @(posedge clk) begin
        if (w_push || w_ovw)
            r_mem[r_wr_ptr] <= {pc, instr, a0};
        if (w_cap)
            r_prev_pc <= pc;
    end

    assign w_rd     = r_mem[r_rd_ptr];
    assign rd_valid = (r_count != '0);
    assign rd_pc    = rd_valid ? w_rd[95:64] : '0;
    assign rd_instr = rd_valid ? w_rd[63:32] : '0;
    assign rd_a0    = rd_valid ? w_rd[31:0]  : '0;
    assign count    = r_count;
    assign overflow = r_overflow;
    assign cycle    = r_cycle;
    assign halt     = (r_state == HALT);
    assign timeout  = (r_state == TOUT);

endmodule

// File: tb/tb_sr_trace_buffer.sv
// Directed bench for sr_trace_buffer. Two instances share every input:
// u0 overwrites when full, u1 drops new samples when full.
module tb_sr_trace_buffer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        clr = 1'b0;
    logic        en = 1'b0;
    logic [31:0] pc = '0;
    logic [31:0] instr = '0;
    logic [31:0] a0 = '0;
    logic        rd_pop = 1'b0;

    logic        u0_valid, u1_valid;
    logic [31:0] u0_pc, u0_instr, u0_a0, u1_pc, u1_instr, u1_a0;
    logic [2:0]  u0_count, u1_count;
    logic        u0_ovf, u1_ovf, u0_halt, u1_halt, u0_tout, u1_tout;
    logic [15:0] u0_cycle, u1_cycle;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    sr_trace_buffer #(.DEPTH(4), .MODE_STOP(0), .TIMEOUT(10), .STALL_LIMIT(3), .CNT_W(16)) u0 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .en(en), .pc(pc), .instr(instr), .a0(a0),
        .rd_pop(rd_pop), .rd_valid(u0_valid), .rd_pc(u0_pc), .rd_instr(u0_instr),
        .rd_a0(u0_a0), .count(u0_count), .overflow(u0_ovf), .cycle(u0_cycle),
        .halt(u0_halt), .timeout(u0_tout));

    sr_trace_buffer #(.DEPTH(4), .MODE_STOP(1), .TIMEOUT(10), .STALL_LIMIT(3), .CNT_W(16)) u1 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .en(en), .pc(pc), .instr(instr), .a0(a0),
        .rd_pop(rd_pop), .rd_valid(u1_valid), .rd_pc(u1_pc), .rd_instr(u1_instr),
        .rd_a0(u1_a0), .count(u1_count), .overflow(u1_ovf), .cycle(u1_cycle),
        .halt(u1_halt), .timeout(u1_tout));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock with the given strobe/pop; outputs are settled 1 time unit after the edge.
    task automatic cyc(input logic e, input logic [31:0] p, input logic pop);
        en     = e;
        pc     = p;
        instr  = p ^ 32'hA5A5_0000;
        a0     = p + 32'd1;
        rd_pop = pop;
        @(posedge clk);
        #1;
        en     = 1'b0;
        rd_pop = 1'b0;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
    endtask

    initial begin
        // Reset state
        #1 rst_n = 1'b0;
        #2;
        chk("rst_count", 32'(u0_count), 32'd0);
        chk("rst_valid", 32'(u0_valid), 32'd0);
        chk("rst_cycle", 32'(u0_cycle), 32'd0);
        chk("rst_ovf",   32'(u0_ovf),   32'd0);
        chk("rst_halt",  32'(u0_halt),  32'd0);
        chk("rst_tout",  32'(u0_tout),  32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // 1: FIFO order
        cyc(1'b1, 32'd0, 1'b0);
        cyc(1'b1, 32'd4, 1'b0);
        cyc(1'b1, 32'd8, 1'b0);
        chk("t1_count", 32'(u0_count), 32'd3);
        chk("t1_pc0", u0_pc, 32'd0);
        chk("t1_instr0", u0_instr, 32'hA5A5_0000);
        chk("t1_a0_0", u0_a0, 32'd1);
        cyc(1'b0, 32'd0, 1'b1);
        chk("t1_pc1", u0_pc, 32'd4);
        cyc(1'b0, 32'd0, 1'b1);
        chk("t1_pc2", u0_pc, 32'd8);
        cyc(1'b0, 32'd0, 1'b1);
        chk("t1_valid", 32'(u0_valid), 32'd0);
        chk("t1_count_end", 32'(u0_count), 32'd0);
        chk("t1_cycle", 32'(u0_cycle), 32'd3);
        cyc(1'b0, 32'd0, 1'b1);
        chk("t1_empty_pop", 32'(u0_count), 32'd0);

        // 2/3: overwrite (u0) vs stop (u1)
        do_clr();
        for (int i = 0; i < 6; i++) cyc(1'b1, 32'(4 * i), 1'b0);
        chk("t2_count", 32'(u0_count), 32'd4);
        chk("t2_ovf", 32'(u0_ovf), 32'd1);
        chk("t3_count", 32'(u1_count), 32'd4);
        chk("t3_ovf", 32'(u1_ovf), 32'd1);
        chk("t3_cycle", 32'(u1_cycle), 32'd6);
        for (int i = 0; i < 4; i++) begin
            chk("t2_pop_pc", u0_pc, 32'(8 + 4 * i));
            chk("t3_pop_pc", u1_pc, 32'(4 * i));
            cyc(1'b0, 32'd0, 1'b1);
        end
        chk("t2_valid_end", 32'(u0_valid), 32'd0);

        // 4: halt on repeated PC
        do_clr();
        cyc(1'b1, 32'd0, 1'b0);
        cyc(1'b1, 32'd4, 1'b0);
        cyc(1'b1, 32'd8, 1'b0);
        cyc(1'b1, 32'd8, 1'b0);
        cyc(1'b1, 32'd8, 1'b0);
        chk("t4_halt_early", 32'(u0_halt), 32'd0);
        cyc(1'b1, 32'd8, 1'b0);
        chk("t4_halt", 32'(u0_halt), 32'd1);
        chk("t4_tout", 32'(u0_tout), 32'd0);
        chk("t4_cycle", 32'(u0_cycle), 32'd6);
        cyc(1'b1, 32'd12, 1'b0);
        chk("t4_cycle_frozen", 32'(u0_cycle), 32'd6);
        chk("t4_count", 32'(u0_count), 32'd4);
        for (int i = 0; i < 3; i++) cyc(1'b0, 32'd0, 1'b1);
        chk("t4_last_pc", u0_pc, 32'd8);
        cyc(1'b0, 32'd0, 1'b1);
        chk("t4_valid_end", 32'(u0_valid), 32'd0);

        // 5: timeout with interleaved pops, then clr
        do_clr();
        for (int i = 0; i < 9; i++) cyc(1'b1, 32'(100 + 4 * i), 1'b1);
        chk("t5_tout_early", 32'(u0_tout), 32'd0);
        cyc(1'b1, 32'd136, 1'b1);
        chk("t5_tout", 32'(u0_tout), 32'd1);
        chk("t5_halt", 32'(u0_halt), 32'd0);
        chk("t5_cycle", 32'(u0_cycle), 32'd10);
        chk("t5_count", 32'(u0_count), 32'd1);
        chk("t5_pc", u0_pc, 32'd136);
        cyc(1'b1, 32'd140, 1'b0);
        chk("t5_cycle_frozen", 32'(u0_cycle), 32'd10);
        do_clr();
        chk("t5_clr_tout", 32'(u0_tout), 32'd0);
        chk("t5_clr_cycle", 32'(u0_cycle), 32'd0);
        chk("t5_clr_count", 32'(u0_count), 32'd0);
        chk("t5_clr_valid", 32'(u0_valid), 32'd0);
        chk("t5_clr_ovf", 32'(u0_ovf), 32'd0);
        chk("t5_clr_halt", 32'(u0_halt), 32'd0);
        chk("t5_clr_rdpc", u0_pc, 32'd0);
        cyc(1'b1, 32'd200, 1'b0);
        chk("t5_resume_pc", u0_pc, 32'd200);
        chk("t5_resume_cycle", 32'(u0_cycle), 32'd1);

        // 6: async reset mid-run, then push+pop while full
        cyc(1'b1, 32'd204, 1'b0);
        cyc(1'b1, 32'd208, 1'b0);
        chk("t6_count_pre", 32'(u0_count), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_count", 32'(u0_count), 32'd0);
        chk("t6_rst_valid", 32'(u0_valid), 32'd0);
        chk("t6_rst_cycle", 32'(u0_cycle), 32'd0);
        chk("t6_rst_ovf", 32'(u0_ovf), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) cyc(1'b1, 32'(300 + 4 * i), 1'b0);
        chk("t6_full", 32'(u0_count), 32'd4);
        cyc(1'b1, 32'd316, 1'b1);
        chk("t6_pp_count", 32'(u0_count), 32'd4);
        chk("t6_pp_ovf", 32'(u0_ovf), 32'd0);
        chk("t6_pp_pc", u0_pc, 32'd304);
        chk("t6_pp_cycle", 32'(u0_cycle), 32'd5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
